// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared snake-game types: heading enum, rotation helpers and
//               default sizing constants for the heading controller.
// Revision    : 1.0 - multi-player heading controller support
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        RIGHT = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        UP    = 3'd4
    } directions;

    localparam int DEFAULT_NUM_PLAYERS = 2;
    localparam int DEFAULT_TURN_DEPTH  = 2;

    // Any out-of-range encoding collapses to WAIT so a corrupted heading self-heals.
    function automatic directions dir_rotate_cw(input directions d);
        case (d)
            WAIT:    return RIGHT;
            RIGHT:   return DOWN;
            DOWN:    return LEFT;
            LEFT:    return UP;
            UP:      return RIGHT;
            default: return WAIT;
        endcase
    endfunction

    function automatic directions dir_rotate_ccw(input directions d);
        case (d)
            WAIT:    return LEFT;
            RIGHT:   return UP;
            UP:      return LEFT;
            LEFT:    return DOWN;
            DOWN:    return RIGHT;
            default: return WAIT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/turn_fifo.sv
`default_nettype none
// ============================================================================
// Module      : turn_fifo
// Description : 1-bit pending-turn buffer. With DIRCTRL_TURN_QUEUE_EN it is a
//               DEPTH-entry FIFO that refuses pushes when full (unless popping);
//               otherwise a single slot where the newest push overwrites.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic dout
);

`ifdef DIRCTRL_TURN_QUEUE_EN
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [c_CNT_W-1:0] r_count;
    logic [DEPTH-1:0]   r_mem;
    logic               w_do_pop;

    assign full     = (r_count == c_CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign dout     = r_mem[0];
    assign w_do_pop = pop & ~empty;

    // Entry 0 is always the head; a pop shifts everything down one place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_mem   <= '0;
        end else if (w_do_pop) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                r_mem[k] <= r_mem[k+1];
            end
            if (push) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k == int'(r_count) - 1) begin
                        r_mem[k] <= din;
                    end
                end
            end else begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end else if (push && !full) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k == int'(r_count)) begin
                    r_mem[k] <= din;
                end
            end
            r_count <= r_count + c_CNT_W'(1);
        end
    end
`else
    logic r_valid;
    logic r_bit;

    // A single overwriting slot can never refuse a push, so it never reports full.
    assign full  = 1'b0;
    assign empty = ~r_valid;
    assign dout  = r_bit;

    if (DEPTH < 1) begin : g_depth_unused
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
        end else if (push) begin
            r_valid <= 1'b1;
            r_bit   <= din;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/direction_control_multi.sv
`default_nettype none
// ============================================================================
// Module      : direction_control_multi
// Description : Per-player snake heading controller. Mouse clicks become
//               buffered relative turns applied on move_tick. Build option
//               DIRCTRL_TURN_QUEUE_EN selects a FIFO per player with drop-on-full.
// Revision    : 1.0 - replaces two-player apply-immediately controller
// ============================================================================
module direction_control_multi
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = DEFAULT_NUM_PLAYERS,
    parameter int TURN_DEPTH  = DEFAULT_TURN_DEPTH,
    parameter int PW          = $clog2(NUM_PLAYERS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mouse_right,
    input  logic          mouse_left,
    input  logic          sel_valid,
    input  logic [PW-1:0] sel_idx,
    input  logic          move_tick,
    input  logic          game_restart,
    output directions     direction [NUM_PLAYERS],
    output logic          turn_drop
);

    logic                   r_right_prev;
    logic                   r_left_prev;
    logic                   r_turn_drop;
    directions              r_dir [NUM_PLAYERS];

    logic                   w_clr;
    logic                   w_right_click;
    logic                   w_left_click;
    logic                   w_click;
    logic                   w_sel_ok;
    logic                   w_drop;
    logic [NUM_PLAYERS-1:0] w_push;
    logic [NUM_PLAYERS-1:0] w_pop;
    logic [NUM_PLAYERS-1:0] w_full;
    logic [NUM_PLAYERS-1:0] w_empty;
    logic [NUM_PLAYERS-1:0] w_dout;

    assign w_clr         = rst | game_restart;
    // Right wins when both buttons rise together.
    assign w_right_click = mouse_right & ~r_right_prev;
    assign w_left_click  = mouse_left & ~r_left_prev & ~w_right_click;
    assign w_click       = w_right_click | w_left_click;
    assign w_sel_ok      = sel_valid & (int'(sel_idx) < NUM_PLAYERS);

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        assign w_push[gi] = w_click & w_sel_ok & (int'(sel_idx) == gi);
        assign w_pop[gi]  = move_tick & ~w_empty[gi];

        turn_fifo #(
            .DEPTH (TURN_DEPTH)
        ) u_turn_fifo (
            .clk   (clk),
            .rst   (w_clr),
            .push  (w_push[gi]),
            .din   (w_right_click),
            .pop   (w_pop[gi]),
            .full  (w_full[gi]),
            .empty (w_empty[gi]),
            .dout  (w_dout[gi])
        );
    end

    assign w_drop = |(w_push & w_full & ~w_pop);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_right_prev <= 1'b1;
            r_left_prev  <= 1'b1;
            r_turn_drop  <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_dir[i] <= WAIT;
            end
        end else begin
            r_right_prev <= mouse_right;
            r_left_prev  <= mouse_left;
            r_turn_drop  <= w_drop;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (w_pop[i]) begin
                    r_dir[i] <= w_dout[i] ? dir_rotate_cw(r_dir[i]) : dir_rotate_ccw(r_dir[i]);
                end
            end
        end
    end

    assign direction = r_dir;
    assign turn_drop = r_turn_drop;

endmodule
`default_nettype wire
